// File: rtl/minsel_pkg.sv
// Shared types and default sizing for the sequential arg-min/arg-max reducer.
package minsel_pkg;

    localparam int DEF_IDX_W = 3;
    localparam int DEF_LEN   = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/minsel_cmp.sv
// Candidate selection rule: masked beats never win, the first unmasked beat
// always wins, later beats win only by strictly beating the current best.
module minsel_cmp #(
    parameter int LEN = minsel_pkg::DEF_LEN
) (
    input  logic [LEN-1:0] key,
    input  logic [LEN-1:0] best,
    input  logic           hit,
    input  logic           skip,
    input  logic           max,
    output logic           take
);

    logic better;

    // Strict compare keeps the earliest index on ties in both modes.
    assign better = max ? (key > best) : (key < best);
    assign take   = !skip && (!hit || better);

endmodule

// File: rtl/minsel_seq.sv
// Serial arg-min/arg-max over a frame of up to 2**IDX_W keys; one beat per
// cycle in, one registered result per frame out.
//
// Handshakes: a beat transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. out_*
// fields are held stable while out_valid && !out_ready.
module minsel_seq
    import minsel_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W,
    parameter int LEN   = DEF_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LEN-1:0]   in_key,
    input  logic             in_skip,
    input  logic             in_last,
    input  logic             in_max,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [LEN-1:0]   out_key,
    output logic             out_hit,
    output state_t           dbg_state
);

    localparam int N_CAND = 2 ** IDX_W;
    localparam logic [IDX_W:0] LAST_POS = (IDX_W + 1)'(N_CAND - 1);

    state_t         state;
    logic [IDX_W:0] cnt;
    logic           mode;

    logic           accept;
    logic           first;
    logic [IDX_W:0] pos;
    logic           frame_end;
    logic           take;

    assign accept    = in_valid && in_ready;
    assign first     = (state == IDLE);
    assign pos       = first ? '0 : cnt;
    assign frame_end = in_last || (pos == LAST_POS);
    assign dbg_state = state;

    // On the first beat the live mode and an empty best drive the decision.
    minsel_cmp #(.LEN(LEN)) u_cmp (
        .key  (in_key),
        .best (out_key),
        .hit  (first ? 1'b0 : out_hit),
        .skip (in_skip),
        .max  (first ? in_max : mode),
        .take (take)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_key   <= '0;
            out_hit   <= 1'b0;
            cnt       <= '0;
            mode      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mode    <= in_max;
                        cnt     <= (IDX_W + 1)'(1);
                        out_hit <= take;
                        out_idx <= '0;
                        out_key <= take ? in_key : '0;
                        if (frame_end) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (accept) begin
                        if (take) begin
                            out_idx <= pos[IDX_W-1:0];
                            out_key <= in_key;
                            out_hit <= 1'b1;
                        end
                        cnt <= cnt + 1'b1;
                        if (frame_end) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minsel_seq.sv
// Bench for minsel_seq: directed frames from the test plan plus randomized
// frames checked against a value-first arg-min/arg-max model.
module tb_minsel_seq;
    import minsel_pkg::*;

    localparam int IDX_W = 3;
    localparam int LEN   = 10;
    localparam int NMAX  = 2 ** IDX_W;
    localparam int RW    = 1 + IDX_W + LEN;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [LEN-1:0]   in_key;
    logic             in_skip;
    logic             in_last;
    logic             in_max;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic [LEN-1:0]   out_key;
    logic             out_hit;
    state_t           dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [LEN-1:0] fr_key[NMAX];
    bit             fr_skip[NMAX];
    logic [RW-1:0]  exp_q[$];

    minsel_seq #(.IDX_W(IDX_W), .LEN(LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_key    (in_key),
        .in_skip   (in_skip),
        .in_last   (in_last),
        .in_max    (in_max),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_key   (out_key),
        .out_hit   (out_hit),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Reference: find the extreme value among unmasked keys, then the first
    // position carrying it. All masked yields a zero result with hit clear.
    function automatic logic [RW-1:0] model(input int n, input bit mx);
        int  best_val;
        int  idx;
        bit  any;
        best_val = mx ? -1 : (1 << LEN);
        any = 0;
        idx = 0;
        for (int i = 0; i < n; i++) begin
            if (!fr_skip[i]) begin
                any = 1;
                if (mx && int'(fr_key[i]) > best_val) best_val = int'(fr_key[i]);
                if (!mx && int'(fr_key[i]) < best_val) best_val = int'(fr_key[i]);
            end
        end
        if (!any) return '0;
        for (int i = n - 1; i >= 0; i--)
            if (!fr_skip[i] && int'(fr_key[i]) == best_val) idx = i;
        return {1'b1, IDX_W'(idx), LEN'(best_val)};
    endfunction

    // Called at a negedge; leaves the bench at the next negedge after acceptance.
    task automatic drive_beat(input logic [LEN-1:0] k, input bit s, input bit l, input bit m);
        int waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL beat_ready: in_ready=%b out_valid=%b expected in_ready=1 out_valid=0", in_ready, out_valid);
        end
        in_valid = 1'b1;
        in_key   = k;
        in_skip  = s;
        in_last  = l;
        in_max   = m;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_frame(input int n, input bit use_last, input bit mx, input bit toggle,
                             input int stall, input bit gaps);
        logic [RW-1:0] e;
        logic [RW-1:0] seen;
        exp_q.push_back(model(n, mx));
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
            drive_beat(fr_key[i], fr_skip[i], use_last && (i == n - 1),
                       (i == 0) ? mx : (toggle ? !mx : 1'($urandom_range(0, 1))));
        end
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL latency: out_valid=%b in_ready=%b expected out_valid=1 in_ready=0", out_valid, in_ready);
        end
        checks++;
        if (out_hit !== e[RW-1]) begin
            failures++;
            $display("FAIL out_hit: got %b expected %b", out_hit, e[RW-1]);
        end
        checks++;
        if (out_idx !== e[RW-2:LEN]) begin
            failures++;
            $display("FAIL out_idx: got %0d expected %0d", out_idx, e[RW-2:LEN]);
        end
        checks++;
        if (out_key !== e[LEN-1:0]) begin
            failures++;
            $display("FAIL out_key: got %0d expected %0d", out_key, e[LEN-1:0]);
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            seen = {out_hit, out_idx, out_key};
            checks++;
            if (seen !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable: cycle %0d result=%h valid=%b ready=%b expected result=%h valid=1 ready=0",
                         s, seen, out_valid, in_ready, e);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dbg_state !== IDLE) begin
            failures++;
            $display("FAIL release: out_valid=%b in_ready=%b state=%0d expected 0/1/IDLE",
                     out_valid, in_ready, dbg_state);
        end
    endtask

    task automatic set_frame(input int n, input int keys[8], input bit skips[8]);
        for (int i = 0; i < n; i++) begin
            fr_key[i]  = LEN'(keys[i]);
            fr_skip[i] = skips[i];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (dbg_state !== IDLE || in_ready !== 1'b1 || out_valid !== 1'b0 ||
            out_idx !== '0 || out_key !== '0 || out_hit !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: state=%0d ready=%b valid=%b idx=%0d key=%0d hit=%b expected IDLE/1/0/0/0/0",
                     dbg_state, in_ready, out_valid, out_idx, out_key, out_hit);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        bit none[8] = '{default: 0};
        bit all3[8] = '{1, 1, 1, 0, 0, 0, 0, 0};
        bit sk2[8]  = '{1, 1, 0, 0, 0, 0, 0, 0};
        set_frame(4, '{40, 12, 33, 12, 0, 0, 0, 0}, none);
        run_frame(4, 1, 0, 0, 0, 0);
        set_frame(8, '{5, 900, 900, 3, 1023, 7, 1023, 0}, none);
        run_frame(8, 0, 1, 0, 0, 0);
        set_frame(3, '{100, 200, 300, 0, 0, 0, 0, 0}, all3);
        run_frame(3, 1, 0, 0, 0, 0);
        set_frame(4, '{1, 2, 50, 20, 0, 0, 0, 0}, sk2);
        run_frame(4, 1, 0, 0, 5, 0);
    endtask

    task automatic test_mode_toggle();
        bit none[8] = '{default: 0};
        set_frame(3, '{9, 2, 15, 0, 0, 0, 0, 0}, none);
        run_frame(3, 1, 0, 1, 0, 0);
    endtask

    task automatic test_reset_mid_frame();
        bit none[8] = '{default: 0};
        drive_beat(10'd300, 1'b0, 1'b0, 1'b0);
        drive_beat(10'd1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || dbg_state !== IDLE) begin
                failures++;
                $display("FAIL abort: cycle %0d out_valid=%b in_ready=%b state=%0d expected 0/1/IDLE",
                         c, out_valid, in_ready, dbg_state);
            end
            @(negedge clk);
        end
        set_frame(1, '{7, 0, 0, 0, 0, 0, 0, 0}, none);
        run_frame(1, 1, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 40; f++) begin
            int  n;
            bit  ul;
            n  = $urandom_range(1, NMAX);
            ul = (n < NMAX) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                fr_key[i]  = ($urandom_range(0, 1) == 1) ? LEN'($urandom_range(0, 7))
                                                        : LEN'($urandom_range(0, 1023));
                fr_skip[i] = ($urandom_range(0, 4) == 0);
            end
            run_frame(n, ul, 1'($urandom_range(0, 1)), 0, $urandom_range(0, 2), 1);
        end
    endtask

    task automatic test_back_to_back();
        bit none[8] = '{default: 0};
        set_frame(2, '{600, 500, 0, 0, 0, 0, 0, 0}, none);
        run_frame(2, 1, 1, 0, 0, 0);
        set_frame(2, '{600, 500, 0, 0, 0, 0, 0, 0}, none);
        run_frame(2, 1, 0, 0, 0, 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_key    = '0;
        in_skip   = 1'b0;
        in_last   = 1'b0;
        in_max    = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_mode_toggle();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
